// File: rtl/alu_issue_unit.sv
// Four-state issue controller for the RV32I integer ALU: accepts an OP/OP-IMM word,
// drives ALU operand controls, captures the result and strobes a register-file write.
module alu_issue_unit #(
    parameter int REG_ADDR_WIDTH     = 5,
    parameter int RETIRE_COUNT_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          instr_valid,
    input  logic [31:0]                   instr,
    output logic                          instr_ready,
    output logic [REG_ADDR_WIDTH-1:0]     register_read_addr_a,
    output logic [REG_ADDR_WIDTH-1:0]     register_read_addr_b,
    output logic                          alu_immediate_enable,
    output logic [31:0]                   immediate_data,
    output logic [3:0]                    operation,
    input  logic [31:0]                   alu_out,
    output logic                          register_write_enable,
    output logic [REG_ADDR_WIDTH-1:0]     register_write_addr,
    output logic [31:0]                   register_write_data,
    output logic                          illegal_instr,
    output logic [RETIRE_COUNT_WIDTH-1:0] retire_count
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] DECODE    = 2'd1;
    localparam logic [1:0] EXECUTE   = 2'd2;
    localparam logic [1:0] WRITEBACK = 2'd3;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    logic [1:0]                    state_reg;
    logic [31:0]                   instr_reg;
    logic [REG_ADDR_WIDTH-1:0]     addr_a_reg;
    logic [REG_ADDR_WIDTH-1:0]     addr_b_reg;
    logic                          imm_en_reg;
    logic [31:0]                   imm_reg;
    logic [3:0]                    op_reg;
    logic [REG_ADDR_WIDTH-1:0]     wr_addr_reg;
    logic [31:0]                   wr_data_reg;
    logic                          illegal_reg;
    logic [RETIRE_COUNT_WIDTH-1:0] retire_reg;

    logic [6:0]                    opcode;
    logic [2:0]                    funct3;
    logic [6:0]                    funct7;
    logic [31:0]                   imm_i;
    logic                          legal_next;
    logic                          imm_en_next;
    logic [31:0]                   imm_next;
    logic [3:0]                    op_next;
    logic [REG_ADDR_WIDTH-1:0]     addr_b_next;

    assign opcode = instr_reg[6:0];
    assign funct3 = instr_reg[14:12];
    assign funct7 = instr_reg[31:25];

    // I-type immediate: low 12 bits from the word, upper bits replicate bit 31
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_imm_i
            if (gi < 12) begin : g_low
                assign imm_i[gi] = instr_reg[20+gi];
            end else begin : g_sign
                assign imm_i[gi] = instr_reg[31];
            end
        end
    endgenerate

    always_comb begin
        legal_next  = 1'b0;
        imm_en_next = 1'b0;
        imm_next    = 32'd0;
        op_next     = {1'b0, funct3};
        addr_b_next = REG_ADDR_WIDTH'(instr_reg[24:20]);
        if (opcode == OPC_OP) begin
            legal_next = (funct7 == F7_ZERO) ||
                         ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            if ((funct3 == 3'b000) || (funct3 == 3'b101)) begin
                op_next[3] = instr_reg[30];
            end
        end else if (opcode == OPC_OP_IMM) begin
            imm_en_next = 1'b1;
            addr_b_next = '0;
            case (funct3)
                3'b001: begin
                    legal_next = (funct7 == F7_ZERO);
                    imm_next   = {27'd0, instr_reg[24:20]};
                end
                3'b101: begin
                    legal_next = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                    imm_next   = {27'd0, instr_reg[24:20]};
                    op_next[3] = instr_reg[30];
                end
                default: begin
                    legal_next = 1'b1;
                    imm_next   = imm_i;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            instr_reg   <= 32'd0;
            addr_a_reg  <= '0;
            addr_b_reg  <= '0;
            imm_en_reg  <= 1'b0;
            imm_reg     <= 32'd0;
            op_reg      <= 4'd0;
            wr_addr_reg <= '0;
            wr_data_reg <= 32'd0;
            illegal_reg <= 1'b0;
            retire_reg  <= '0;
        end else begin
            illegal_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (instr_valid) begin
                        instr_reg <= instr;
                        state_reg <= DECODE;
                    end
                end
                DECODE: begin
                    if (legal_next) begin
                        addr_a_reg  <= REG_ADDR_WIDTH'(instr_reg[19:15]);
                        addr_b_reg  <= addr_b_next;
                        imm_en_reg  <= imm_en_next;
                        imm_reg     <= imm_next;
                        op_reg      <= op_next;
                        wr_addr_reg <= REG_ADDR_WIDTH'(instr_reg[11:7]);
                        state_reg   <= EXECUTE;
                    end else begin
                        illegal_reg <= 1'b1;
                        state_reg   <= IDLE;
                    end
                end
                EXECUTE: begin
                    wr_data_reg <= alu_out;
                    state_reg   <= WRITEBACK;
                end
                WRITEBACK: begin
                    retire_reg <= retire_reg + RETIRE_COUNT_WIDTH'(1);
                    state_reg  <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign instr_ready           = (state_reg == IDLE);
    assign register_read_addr_a  = addr_a_reg;
    assign register_read_addr_b  = addr_b_reg;
    assign alu_immediate_enable  = imm_en_reg;
    assign immediate_data        = imm_reg;
    assign operation             = op_reg;
    // x0 is never written, but the instruction still retires
    assign register_write_enable = (state_reg == WRITEBACK) && (wr_addr_reg != '0);
    assign register_write_addr   = wr_addr_reg;
    assign register_write_data   = wr_data_reg;
    assign illegal_instr         = illegal_reg;
    assign retire_count          = retire_reg;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Scoreboard bench for alu_issue_unit: stimulus pushes expected completions,
// a negedge monitor pops and compares on write strobes, retirements and illegal pulses.
module tb_alu_issue_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [4:0]  register_read_addr_a;
    logic [4:0]  register_read_addr_b;
    logic        alu_immediate_enable;
    logic [31:0] immediate_data;
    logic [3:0]  operation;
    logic [31:0] alu_out;
    logic        register_write_enable;
    logic [4:0]  register_write_addr;
    logic [31:0] register_write_data;
    logic        illegal_instr;
    logic [31:0] retire_count;

    alu_issue_unit dut (
        .clk                   (clk),
        .rst                   (rst),
        .instr_valid           (instr_valid),
        .instr                 (instr),
        .instr_ready           (instr_ready),
        .register_read_addr_a  (register_read_addr_a),
        .register_read_addr_b  (register_read_addr_b),
        .alu_immediate_enable  (alu_immediate_enable),
        .immediate_data        (immediate_data),
        .operation             (operation),
        .alu_out               (alu_out),
        .register_write_enable (register_write_enable),
        .register_write_addr   (register_write_addr),
        .register_write_data   (register_write_data),
        .illegal_instr         (illegal_instr),
        .retire_count          (retire_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        illegal;
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  op;
        logic [31:0] imm;
        logic        imm_en;
        logic [4:0]  a;
        logic [4:0]  b;
        int          retire;
    } item_t;

    item_t q[$];
    int    acc_log[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    last_acc = 0;
    int    exp_retire = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Register file model: x1 negative so arithmetic shifts are exercised
    function automatic logic [31:0] regval(input logic [4:0] idx);
        case (idx)
            5'd1:    return 32'h8000_0010;
            5'd2:    return 32'h0000_0004;
            default: return 32'h0;
        endcase
    endfunction

    // ALU model; output is scrambled during the write strobe so a late capture shows up
    logic [31:0] op_a, op_b;
    always @* begin
        op_a = regval(register_read_addr_a);
        op_b = alu_immediate_enable ? immediate_data : regval(register_read_addr_b);
        case (operation)
            4'b0000: alu_out = op_a + op_b;
            4'b1000: alu_out = op_a - op_b;
            4'b0001: alu_out = op_a << op_b[4:0];
            4'b0010: alu_out = {31'd0, $signed(op_a) < $signed(op_b)};
            4'b0011: alu_out = {31'd0, op_a < op_b};
            4'b0100: alu_out = op_a ^ op_b;
            4'b0101: alu_out = op_a >> op_b[4:0];
            4'b1101: alu_out = $unsigned($signed(op_a) >>> op_b[4:0]);
            4'b0110: alu_out = op_a | op_b;
            4'b0111: alu_out = op_a & op_b;
            default: alu_out = 32'h0;
        endcase
        if (register_write_enable) alu_out = 32'hDEAD_BEEF;
    end

    always @(posedge clk) begin
        if (!rst && instr_valid && instr_ready) begin
            acc_log.push_back(cyc);
            last_acc = cyc;
        end
        cyc = cyc + 1;
    end

    // Monitor
    int          prev_retire = 0;
    logic        prev_ill = 1'b0;
    int          wr_cnt = 0;
    logic [4:0]  cap_addr;
    logic [31:0] cap_data;
    always @(negedge clk) begin
        item_t it;
        if (rst) begin
            prev_retire = 0;
            prev_ill    = 1'b0;
            wr_cnt      = 0;
        end else begin
            if (register_write_enable) begin
                wr_cnt++;
                cap_addr = register_write_addr;
                cap_data = register_write_data;
                chk("wb_latency", cyc - last_acc, 3);
                chk("ready_low_in_wb", instr_ready, 1'b0);
            end
            if (illegal_instr) begin
                chk("illegal_single_pulse", prev_ill, 1'b0);
                chk("illegal_expected", q.size() != 0, 1'b1);
                if (q.size() != 0) begin
                    it = q.pop_front();
                    chk("illegal_kind", it.illegal, 1'b1);
                    chk("illegal_retire", retire_count, it.retire);
                    chk("illegal_no_write", wr_cnt, 0);
                    chk("illegal_ready", instr_ready, 1'b1);
                end
                wr_cnt = 0;
            end
            if (retire_count != prev_retire) begin
                chk("retire_expected", q.size() != 0, 1'b1);
                if (q.size() != 0) begin
                    it = q.pop_front();
                    chk("retire_kind", it.illegal, 1'b0);
                    chk("retire_count", retire_count, it.retire);
                    chk("write_strobes", wr_cnt, it.wr ? 1 : 0);
                    if (it.wr) begin
                        chk("write_addr", cap_addr, it.addr);
                        chk("write_data", cap_data, it.data);
                    end
                    chk("operation", operation, it.op);
                    chk("immediate_data", immediate_data, it.imm);
                    chk("imm_enable", alu_immediate_enable, it.imm_en);
                    chk("addr_a", register_read_addr_a, it.a);
                    chk("addr_b", register_read_addr_b, it.b);
                    $display("retired #%0d op=%h rd=%0d data=%h", retire_count, operation,
                             register_write_addr, register_write_data);
                end
                wr_cnt = 0;
            end
            prev_ill    = illegal_instr;
            prev_retire = retire_count;
        end
    end

    task automatic push_legal(input logic wr, input logic [4:0] addr, input logic [31:0] data,
                              input logic [3:0] op, input logic [31:0] imm, input logic en,
                              input logic [4:0] a, input logic [4:0] b);
        item_t it;
        exp_retire++;
        it.illegal = 1'b0; it.wr = wr; it.addr = addr; it.data = data; it.op = op;
        it.imm = imm; it.imm_en = en; it.a = a; it.b = b; it.retire = exp_retire;
        q.push_back(it);
    endtask

    task automatic push_illegal();
        item_t it;
        it.illegal = 1'b1; it.wr = 1'b0; it.addr = '0; it.data = '0; it.op = '0;
        it.imm = '0; it.imm_en = 1'b0; it.a = '0; it.b = '0; it.retire = exp_retire;
        q.push_back(it);
    endtask

    task automatic issue(input logic [31:0] w, input logic hold);
        int n0;
        n0 = acc_log.size();
        instr = w;
        instr_valid = 1'b1;
        for (int i = 0; i < 20 && acc_log.size() == n0; i++) @(negedge clk);
        chk("accept_timeout", acc_log.size() > n0, 1'b1);
        $display("issued %h", w);
        if (!hold) instr_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("queue_drained", q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, instr_ready, 1'b1);
        chk({tag, "_wen"}, register_write_enable, 1'b0);
        chk({tag, "_illegal"}, illegal_instr, 1'b0);
        chk({tag, "_retire"}, retire_count, 0);
        chk({tag, "_addr_a"}, register_read_addr_a, 0);
        chk({tag, "_addr_b"}, register_read_addr_b, 0);
        chk({tag, "_imm_en"}, alu_immediate_enable, 1'b0);
        chk({tag, "_imm"}, immediate_data, 0);
        chk({tag, "_op"}, operation, 0);
        chk({tag, "_waddr"}, register_write_addr, 0);
        chk({tag, "_wdata"}, register_write_data, 0);
    endtask

    initial begin
        int n0;
        rst = 1'b1;
        instr_valid = 1'b0;
        instr = 32'h0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", instr_ready, 1'b1);

        // ADDI x5,x1,-3
        push_legal(1'b1, 5'd5, 32'h8000_000D, 4'b0000, 32'hFFFF_FFFD, 1'b1, 5'd1, 5'd0);
        issue(32'hFFD0_8293, 1'b0);
        // SUB x3,x1,x2
        push_legal(1'b1, 5'd3, 32'h8000_000C, 4'b1000, 32'h0, 1'b0, 5'd1, 5'd2);
        issue(32'h4020_81B3, 1'b0);
        // SRA x4,x1,x2
        push_legal(1'b1, 5'd4, 32'hF800_0001, 4'b1101, 32'h0, 1'b0, 5'd1, 5'd2);
        issue(32'h4020_D233, 1'b0);
        // SRAI x4,x1,7
        push_legal(1'b1, 5'd4, 32'hFF00_0000, 4'b1101, 32'h7, 1'b1, 5'd1, 5'd0);
        issue(32'h4070_D213, 1'b0);
        // ADD x0,x1,x2: retires without a write
        push_legal(1'b0, 5'd0, 32'h0, 4'b0000, 32'h0, 1'b0, 5'd1, 5'd2);
        issue(32'h0020_8033, 1'b0);
        // LW and OP with funct7=0000001
        push_illegal();
        issue(32'h0000_A083, 1'b0);
        push_illegal();
        issue(32'h0220_80B3, 1'b0);
        drain();

        // Back-to-back with instr_valid held: XORI x6,x2,0xFF; SLLI x7,x2,3; OR x8,x1,x2
        n0 = acc_log.size();
        push_legal(1'b1, 5'd6, 32'h0000_00FB, 4'b0100, 32'h0000_00FF, 1'b1, 5'd2, 5'd0);
        issue(32'h0FF1_4313, 1'b1);
        push_legal(1'b1, 5'd7, 32'h0000_0020, 4'b0001, 32'h0000_0003, 1'b1, 5'd2, 5'd0);
        issue(32'h0031_1393, 1'b1);
        push_legal(1'b1, 5'd8, 32'h8000_0014, 4'b0110, 32'h0, 1'b0, 5'd1, 5'd2);
        issue(32'h0020_E433, 1'b0);
        chk("b2b_accepts", acc_log.size() - n0, 3);
        if (acc_log.size() - n0 >= 3) begin
            chk("b2b_gap1", acc_log[n0+1] - acc_log[n0], 4);
            chk("b2b_gap2", acc_log[n0+2] - acc_log[n0+1], 4);
        end
        drain();
        chk("retire_before_reset", retire_count, 8);

        // Reset during EXECUTE of ADDI x9,x1,1 drops it
        issue(32'h0010_8493, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        rst = 1'b0;
        @(negedge clk);
        chk("midreset_ready_after", instr_ready, 1'b1);
        chk("midreset_no_write", register_write_enable, 1'b0);
        exp_retire = 0;
        push_legal(1'b1, 5'd9, 32'h8000_0011, 4'b0000, 32'h1, 1'b1, 5'd1, 5'd0);
        issue(32'h0010_8493, 1'b0);
        drain();
        chk("stray_write_strobes", wr_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
